brush_stroke_painter: RTL and testbench
=======================================

# brush_stroke_painter

Upstream feeder for `graphic_manager`. Converts accepted touch coordinates into a clipped square brush of white pixels and serves canvas-clear requests by writing every pixel black. Pixel writes are paced to `graphic_manager`'s one-write-per-two-cycles acceptance. Sits between the touch-coordinate source and the `bw_pixel_color` / `pixel_col` / `pixel_row` / `write_pixel` inputs of `graphic_manager`.

## Interface
- `BRUSH_RADIUS`, default 1: brush half-width. Side = 2·R+1, so 3×3 at the default.
- `COL_NUM`, default 320: screen columns.
- `ROW_NUM`, default 240: screen rows.
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `en`  in  1  global enable. Same signal that drives `graphic_manager.en`.
- `gm_initialized`  in  1  `initialized` output of `graphic_manager`.
- `touch_valid`  in  1  touch coordinate valid.
- `touch_x`  in  9  touch column.
- `touch_y`  in  8  touch row.
- `touch_ready`  out  1  accepting a touch.
- `clear_req`  in  1  request a full-canvas clear (pulse or level).
- `busy`  out  1  painter not in IDLE.
- `bw_pixel_color`  out  1  pixel color: 1 = white for brush, 0 = black for clear.
- `pixel_col`  out  9  write column.
- `pixel_row`  out  8  write row.
- `write_pixel`  out  1  one-cycle write strobe.

## Operation
- **States:** WAIT_INIT, IDLE, SETUP, WR, GAP. The mode flag selects BRUSH or CLEAR.
- **WAIT_INIT:** entered at reset. Moves to IDLE on the cycle after `gm_initialized` = 1.
- **IDLE:**
  - `touch_ready` = 1.
  - A pending clear (`clear_req` now, or the latched `clear_pending`) has priority. It goes to SETUP with mode CLEAR, bounds col 0..COL_NUM-1 and row 0..ROW_NUM-1. `touch_ready` is forced to 0 that cycle.
  - Otherwise, `touch_valid` & `touch_ready` accepts the touch.
  - An in-range touch (`touch_x` < COL_NUM and `touch_y` < ROW_NUM) registers x/y and goes to SETUP with mode BRUSH.
  - An out-of-range touch is consumed and dropped; the block stays in IDLE.
- **SETUP (one cycle):** computes clipped bounds.
  - c0 = max(x−R, 0), c1 = min(x+R, COL_NUM−1).
  - r0 = max(y−R, 0), r1 = min(y+R, ROW_NUM−1).
  - Subtraction uses signed, widened arithmetic; no underflow wrap.
  - Loads `pixel_col` = c0 and `pixel_row` = r0. Sets `bw_pixel_color` = 1 for BRUSH, 0 for CLEAR.
- **WR:**
  - `write_pixel` = `en`. If `en` = 0, stay in WR with outputs held.
  - If `en` = 1, go to GAP.
- **GAP:**
  - `write_pixel` = 0 and the coordinates are held, so `graphic_manager` sees stable coordinates on the strobe cycle and the following cycle.
  - Then advance in row-major order: if col < c1, col+1 → WR. Else if row < r1, col = c0 and row+1 → WR. Else → IDLE.
- **Clear during a brush:** `clear_req` seen in any state other than IDLE sets `clear_pending`. It is serviced on return to IDLE and cleared on entry to the CLEAR SETUP. A `clear_req` during a CLEAR is absorbed into `clear_pending` and causes exactly one further clear.
- **Touches while busy:** `touch_ready` = 0; the touch is not latched.

## Timing
- **Reset values:** state WAIT_INIT, `write_pixel` 0, `pixel_col` 0, `pixel_row` 0, `bw_pixel_color` 0, `touch_ready` 0, `busy` 1, `clear_pending` 0.
- **Output derivation:**
  - All pixel outputs are registered.
  - `touch_ready` = (state == IDLE) & ~(`clear_req` | `clear_pending`).
  - `busy` = (state != IDLE).
- **Brush latency:** accept at cycle T → SETUP at T+1 → first `write_pixel` at T+2. Successive strobes are exactly 2 cycles apart while `en` = 1.
- **Brush duration:** N pixels take 2N cycles after SETUP, then IDLE. A full 3×3 returns to IDLE at T+20, with `touch_ready` = 1 from that cycle.
- **Strobe spacing:** never two `write_pixel` strobes in consecutive cycles.
- **Reset mid-operation:** `reset_n` low aborts immediately and asynchronously to reset values. After release, WAIT_INIT re-qualifies on `gm_initialized`.
- **Full clear:** COL_NUM·ROW_NUM strobes, i.e. 76 800 strobes over 153 600 cycles after SETUP.

## Test plan
- **Init gating:** hold `gm_initialized` = 0 for 50 cycles with `touch_valid` = 1 → `touch_ready` = 0 and no `write_pixel`. Raise `gm_initialized` → `touch_ready` = 1 two cycles later.
- **Interior brush:** touch (100, 50) → 9 strobes, color 1, coordinates (99..101, 49..51) in row-major order, strobes 2 cycles apart, first strobe 2 cycles after accept.
- **Corner clipping:** touch (0, 0) → 4 strobes at (0,0), (1,0), (0,1), (1,1). Touch (319, 239) → 4 strobes at (318..319, 238..239). Touch (320, 5) → consumed, no strobes.
- **`en` stall:** drop `en` for 7 cycles mid-brush → `write_pixel` low and coordinates frozen for the duration. Resume completes all 9 pixels with no duplicates or omissions.
- **Clear priority and pending:**
  - `clear_req` and `touch_valid` together in IDLE → clear runs: 76 800 strobes, color 0, ending at (319, 239).
  - `clear_req` pulsed during a brush → brush completes, then exactly one clear follows.
- **Async reset mid-clear:** assert `reset_n` = 0 at strobe 1000 → outputs return to reset values the same cycle with no further strobes.

Source files
------------

// File: rtl/brush_stroke_painter.sv
// Paints a clipped square brush of white pixels per accepted touch, or a black full-canvas
// clear, into graphic_manager at one pixel write every two cycles.
module brush_stroke_painter #(
    parameter int BRUSH_RADIUS = 1,
    parameter int COL_NUM      = 320,
    parameter int ROW_NUM      = 240
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic       gm_initialized,
    input  logic       touch_valid,
    input  logic [8:0] touch_x,
    input  logic [7:0] touch_y,
    output logic       touch_ready,
    input  logic       clear_req,
    output logic       busy,
    output logic       bw_pixel_color,
    output logic [8:0] pixel_col,
    output logic [7:0] pixel_row,
    output logic       write_pixel
);

    localparam int unsigned COL_W = 9;
    localparam int unsigned ROW_W = 8;

    typedef enum logic [2:0] {
        WAIT_INIT,
        IDLE,
        SETUP,
        WR,
        GAP
    } state_t;

    typedef enum logic {
        MODE_BRUSH,
        MODE_CLEAR
    } mode_t;

    state_t             state_q, state_d;
    mode_t              mode_q, mode_d;
    logic               pending_q, pending_d;
    logic [COL_W-1:0]   x_q, x_d;
    logic [ROW_W-1:0]   y_q, y_d;
    logic [COL_W-1:0]   c0_q, c0_d;
    logic [COL_W-1:0]   c1_q, c1_d;
    logic [ROW_W-1:0]   r1_q, r1_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               color_q, color_d;

    int                 x_lo, x_hi, y_lo, y_hi;
    logic [COL_W-1:0]   brush_c0, brush_c1;
    logic [ROW_W-1:0]   brush_r0, brush_r1;
    logic               touch_in_range;
    logic               clear_now;

    // Brush bounds clipped to the screen; widened signed math avoids wrap at the edges
    always_comb begin
        x_lo     = int'(x_q) - BRUSH_RADIUS;
        x_hi     = int'(x_q) + BRUSH_RADIUS;
        y_lo     = int'(y_q) - BRUSH_RADIUS;
        y_hi     = int'(y_q) + BRUSH_RADIUS;
        brush_c0 = (x_lo < 0) ? '0 : COL_W'(x_lo);
        brush_c1 = (x_hi > COL_NUM - 1) ? COL_W'(COL_NUM - 1) : COL_W'(x_hi);
        brush_r0 = (y_lo < 0) ? '0 : ROW_W'(y_lo);
        brush_r1 = (y_hi > ROW_NUM - 1) ? ROW_W'(ROW_NUM - 1) : ROW_W'(y_hi);
    end

    assign touch_in_range = (int'(touch_x) < COL_NUM) && (int'(touch_y) < ROW_NUM);
    assign clear_now      = clear_req || pending_q;

    assign touch_ready    = (state_q == IDLE) && !clear_now;
    assign busy           = (state_q != IDLE);
    // Strobe is gated by en so no write lands while graphic_manager is disabled
    assign write_pixel    = (state_q == WR) && en;

    assign pixel_col      = col_q;
    assign pixel_row      = row_q;
    assign bw_pixel_color = color_q;

    // Next-state and datapath updates
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        pending_d = pending_q;
        x_d       = x_q;
        y_d       = y_q;
        c0_d      = c0_q;
        c1_d      = c1_q;
        r1_d      = r1_q;
        col_d     = col_q;
        row_d     = row_q;
        color_d   = color_q;

        if (clear_req && (state_q != IDLE)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            WAIT_INIT: begin
                if (gm_initialized) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (clear_now) begin
                    state_d   = SETUP;
                    mode_d    = MODE_CLEAR;
                    pending_d = 1'b0;
                end else if (touch_valid && touch_in_range) begin
                    state_d = SETUP;
                    mode_d  = MODE_BRUSH;
                    x_d     = touch_x;
                    y_d     = touch_y;
                end
            end
            SETUP: begin
                state_d = WR;
                if (mode_q == MODE_BRUSH) begin
                    c0_d    = brush_c0;
                    c1_d    = brush_c1;
                    r1_d    = brush_r1;
                    col_d   = brush_c0;
                    row_d   = brush_r0;
                    color_d = 1'b1;
                end else begin
                    c0_d    = '0;
                    c1_d    = COL_W'(COL_NUM - 1);
                    r1_d    = ROW_W'(ROW_NUM - 1);
                    col_d   = '0;
                    row_d   = '0;
                    color_d = 1'b0;
                end
            end
            WR: begin
                if (en) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                // Row-major walk over the bounding box
                if (col_q < c1_q) begin
                    col_d   = col_q + COL_W'(1);
                    state_d = WR;
                end else if (row_q < r1_q) begin
                    col_d   = c0_q;
                    row_d   = row_q + ROW_W'(1);
                    state_d = WR;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = WAIT_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= WAIT_INIT;
            mode_q    <= MODE_BRUSH;
            pending_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            c0_q      <= '0;
            c1_q      <= '0;
            r1_q      <= '0;
            col_q     <= '0;
            row_q     <= '0;
            color_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
            x_q       <= x_d;
            y_q       <= y_d;
            c0_q      <= c0_d;
            c1_q      <= c1_d;
            r1_q      <= r1_d;
            col_q     <= col_d;
            row_q     <= row_d;
            color_q   <= color_d;
        end
    end

endmodule

// File: tb/tb_brush_stroke_painter.sv
// Randomized and directed bench for brush_stroke_painter against a pixel-list reference model.
module tb_brush_stroke_painter;

    localparam int R    = 1;
    localparam int COLS = 128;
    localparam int ROWS = 64;
    localparam int NPIX = COLS * ROWS;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic       gm_initialized;
    logic       touch_valid;
    logic [8:0] touch_x;
    logic [7:0] touch_y;
    logic       touch_ready;
    logic       clear_req;
    logic       busy;
    logic       bw_pixel_color;
    logic [8:0] pixel_col;
    logic [7:0] pixel_row;
    logic       write_pixel;

    brush_stroke_painter #(
        .BRUSH_RADIUS (R),
        .COL_NUM      (COLS),
        .ROW_NUM      (ROWS)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .en             (en),
        .gm_initialized (gm_initialized),
        .touch_valid    (touch_valid),
        .touch_x        (touch_x),
        .touch_y        (touch_y),
        .touch_ready    (touch_ready),
        .clear_req      (clear_req),
        .busy           (busy),
        .bw_pixel_color (bw_pixel_color),
        .pixel_col      (pixel_col),
        .pixel_row      (pixel_row),
        .write_pixel    (write_pixel)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c;
        int r;
        int color;
        int cyc;
    } strobe_t;

    typedef struct {
        int c;
        int r;
    } xy_t;

    strobe_t seen[$];
    xy_t     exp_q[$];
    int      cyc          = 0;
    int      last_wp      = -10;
    int      spacing_viol = 0;
    int      errors       = 0;
    int      checks       = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe recorder, sampled mid-cycle
    always @(negedge clk) begin
        if (write_pixel === 1'b1) begin
            if (cyc == last_wp + 1) spacing_viol++;
            last_wp = cyc;
            seen.push_back('{int'(pixel_col), int'(pixel_row), int'(bw_pixel_color), cyc});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int pk(input int c, input int r, input int color);
        return color * (1 << 24) + c * 4096 + r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: every on-screen pixel of the (2R+1)^2 square, row-major
    task automatic build_brush(input int x, input int y);
        exp_q.delete();
        if (x < COLS && y < ROWS) begin
            for (int r = y - R; r <= y + R; r++)
                for (int c = x - R; c <= x + R; c++)
                    if (c >= 0 && c < COLS && r >= 0 && r < ROWS) exp_q.push_back('{c, r});
        end
    endtask

    task automatic send_touch(input int x, input int y, output int acc);
        acc = -1;
        tick();
        touch_valid = 1'b1;
        touch_x     = 9'(x);
        touch_y     = 8'(y);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (touch_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) check("accept_timeout", 32'(touch_ready), 1);
        @(posedge clk);
        #1;
        touch_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int idle_cyc);
        idle_cyc = -1;
        repeat (3) @(negedge clk);
        for (int n = 0; n < budget; n++) begin
            if (!busy) begin
                idle_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (idle_cyc < 0) check("idle_timeout", 32'(busy), 0);
    endtask

    task automatic wait_strobes(input int cnt);
        for (int n = 0; n < 5 * cnt + 100; n++) begin
            @(negedge clk);
            #1;
            if (seen.size() >= cnt) break;
        end
        check("strobe_wait", seen.size() >= cnt, 1);
    endtask

    task automatic cmp_brush(input string tag, input int base, input int acc, input bit timed);
        int n;
        n = (seen.size() - base < exp_q.size()) ? seen.size() - base : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_pix"}, pk(seen[base+i].c, seen[base+i].r, seen[base+i].color),
                  pk(exp_q[i].c, exp_q[i].r, 1));
            if (timed) check({tag, "_time"}, seen[base+i].cyc, acc + 2 + 2 * i);
        end
    endtask

    task automatic run_brush(input int x, input int y, input string tag);
        int acc, idle;
        build_brush(x, y);
        seen.delete();
        send_touch(x, y, acc);
        wait_idle(200, idle);
        check({tag, "_count"}, seen.size(), exp_q.size());
        cmp_brush(tag, 0, acc, 1'b1);
        if (exp_q.size() > 0) check({tag, "_idle"}, idle, acc + 2 + 2 * exp_q.size());
        check({tag, "_ready"}, 32'(touch_ready), 1);
    endtask

    task automatic verify_clear(input string tag, input int base);
        int bad;
        bad = 0;
        for (int i = 0; i < NPIX && base + i < seen.size(); i++) begin
            if (pk(seen[base+i].c, seen[base+i].r, seen[base+i].color) != pk(i % COLS, i / COLS, 0))
                bad++;
        end
        check({tag, "_order"}, bad, 0);
        if (seen.size() > 0)
            check({tag, "_last"}, pk(seen[seen.size()-1].c, seen[seen.size()-1].r, seen[seen.size()-1].color),
                  pk(COLS - 1, ROWS - 1, 0));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_wp"},    32'(write_pixel), 0);
        check({tag, "_col"},   32'(pixel_col), 0);
        check({tag, "_row"},   32'(pixel_row), 0);
        check({tag, "_color"}, 32'(bw_pixel_color), 0);
        check({tag, "_ready"}, 32'(touch_ready), 0);
        check({tag, "_busy"},  32'(busy), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int acc, idle, bad, pc, pr;
        reset_n = 1'b0; en = 1'b1; gm_initialized = 1'b0;
        touch_valid = 1'b0; clear_req = 1'b0; touch_x = '0; touch_y = '0;
        #2;
        check_reset_vals("rst");

        // Init gating with a touch held valid
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1; touch_valid = 1'b1; touch_x = 9'd100; touch_y = 8'd50;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (touch_ready !== 1'b0) bad++;
        end
        check("gate_ready", bad, 0);
        check("gate_wp", seen.size(), 0);
        tick();
        touch_valid = 1'b0; gm_initialized = 1'b1;
        @(negedge clk);
        check("init_ready_c0", 32'(touch_ready), 0);
        @(negedge clk);
        check("init_ready_c1", 32'(touch_ready), 1);

        run_brush(100, 50, "interior");
        run_brush(0, 0, "corner_lo");
        run_brush(COLS - 1, ROWS - 1, "corner_hi");
        run_brush(COLS, 5, "oor");

        for (int i = 0; i < 12; i++)
            run_brush(int'($urandom_range(0, COLS + 2)), int'($urandom_range(0, ROWS + 2)), "rand");

        // en stall in the middle of a brush
        build_brush(60, 30);
        seen.delete();
        send_touch(60, 30, acc);
        wait_strobes(4);
        @(posedge clk);
        @(posedge clk);
        #1;
        en = 1'b0;
        pc = int'(pixel_col);
        pr = int'(pixel_row);
        repeat (7) begin
            @(negedge clk);
            check("stall_hold", pk(pixel_col, pixel_row, write_pixel), pk(pc, pr, 0));
        end
        tick();
        en = 1'b1;
        wait_idle(200, idle);
        check("stall_count", seen.size(), 9);
        cmp_brush("stall", 0, acc, 1'b0);
        check("stall_idle", idle, acc + 20 + 7);

        // Clear wins over a simultaneous touch
        seen.delete();
        tick();
        clear_req = 1'b1; touch_valid = 1'b1; touch_x = 9'd100; touch_y = 8'd50;
        @(negedge clk);
        check("clr_prio_ready", 32'(touch_ready), 0);
        acc = cyc;
        tick();
        clear_req = 1'b0; touch_valid = 1'b0;
        wait_idle(NPIX * 2 + 100, idle);
        check("clr_count", seen.size(), NPIX);
        verify_clear("clr", 0);
        check("clr_idle", idle, acc + 2 + 2 * NPIX);

        // Clear pulsed during a brush runs once afterwards
        build_brush(10, 10);
        seen.delete();
        send_touch(10, 10, acc);
        wait_strobes(3);
        tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        wait_idle(200, idle);
        check("pend_brush_idle", idle, acc + 20);
        check("pend_ready", 32'(touch_ready), 0);
        wait_idle(NPIX * 2 + 100, idle);
        check("pend_count", seen.size(), 9 + NPIX);
        cmp_brush("pend_brush", 0, acc, 1'b1);
        verify_clear("pend_clr", 9);
        repeat (20) @(negedge clk);
        #1;
        check("pend_once", seen.size(), 9 + NPIX);
        check("pend_busy", 32'(busy), 0);

        // Asynchronous reset in the middle of a clear
        seen.delete();
        tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        wait_strobes(1000);
        reset_n = 1'b0;
        gm_initialized = 1'b0;
        #1;
        check_reset_vals("midrst");
        repeat (10) @(negedge clk);
        #1;
        check("midrst_nostrobe", seen.size(), 1000);
        tick();
        reset_n = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (touch_ready !== 1'b0 || write_pixel !== 1'b0) bad++;
        end
        check("requal_gate", bad, 0);
        tick();
        gm_initialized = 1'b1;
        @(negedge clk);
        check("requal_c0", 32'(touch_ready), 0);
        @(negedge clk);
        check("requal_c1", 32'(touch_ready), 1);
        run_brush(5, 7, "post_rst");

        check("spacing", spacing_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
